// File: rtl/pipelined_dadda_multiplier.sv
// Pipelined WIDTH x WIDTH multiplier, signed (Baugh-Wooley) or unsigned per operation,
// with valid/ready flow control; partial products are compressed on Dadda height levels.
module pipelined_dadda_multiplier #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 is_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   ans,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);
    localparam int PW   = 2 * WIDTH;
    localparam int MAXR = WIDTH;

    typedef logic [MAXR-1:0][PW-1:0] rows_t;

    function automatic int dadda_below(input int h);
        int d;
        d = 2;
        if (h <= 2) begin
            return h;
        end
        while ((d * 3) / 2 < h) begin
            d = (d * 3) / 2;
        end
        return d;
    endfunction

    function automatic int height_after(input int n0, input int lvl);
        int h;
        h = n0;
        for (int i = 0; i < lvl; i++) begin
            h = dadda_below(h);
        end
        return h;
    endfunction

    function automatic int num_levels(input int n0);
        int h;
        int cnt;
        h   = n0;
        cnt = 0;
        while (h > 2) begin
            h   = dadda_below(h);
            cnt = cnt + 1;
        end
        return cnt;
    endfunction

    // With no reduction stages (STAGES=2) the last stage owns every level.
    function automatic int stage_lo(input int k, input int nred, input int nlev);
        if (nred == 0 || k >= STAGES) begin
            return 0;
        end
        return ((k - 2) * nlev) / nred;
    endfunction

    function automatic int stage_hi(input int k, input int nred, input int nlev);
        if (nred == 0) begin
            return (k == STAGES) ? nlev : 0;
        end
        if (k >= STAGES) begin
            return 0;
        end
        return ((k - 1) * nlev) / nred;
    endfunction

    function automatic rows_t gen_pp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic sgn);
        rows_t            r;
        logic [WIDTH-1:0] row;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            row = a & {WIDTH{b[i]}};
            if (sgn) begin
                if (i == WIDTH - 1) begin
                    row = {row[WIDTH-1], ~row[WIDTH-2:0]};
                end else begin
                    row[WIDTH-1] = ~row[WIDTH-1];
                end
            end
            r[i] = {{WIDTH{1'b0}}, row} << i;
        end
        // Baugh-Wooley correction constants fit in the empty upper bits of row 0.
        r[0][WIDTH] = sgn;
        r[0][PW-1]  = sgn;
        return r;
    endfunction

    // One carry-save level: (n - h) row-wise 3:2 compressors bring n rows down to h.
    function automatic rows_t csa_level(input rows_t r, input int n, input int h);
        rows_t         o;
        logic [PW-1:0] a;
        logic [PW-1:0] b;
        logic [PW-1:0] c;
        int            k;
        o = '0;
        k = n - h;
        for (int t = 0; t < MAXR / 3; t++) begin
            if (t < k) begin
                a            = r[3*t];
                b            = r[3*t+1];
                c            = r[3*t+2];
                o[2*t]       = a ^ b ^ c;
                o[2*t+1]     = ((a & b) | (a & c) | (b & c)) << 1;
            end
        end
        for (int i = 0; i < MAXR; i++) begin
            if (i >= 3 * k && i < n) begin
                o[i-k] = r[i];
            end
        end
        return o;
    endfunction

    function automatic logic [PW-1:0] final_add(input rows_t r);
        return r[0] + r[1];
    endfunction

    localparam int NLEV = num_levels(WIDTH);
    localparam int NRED = STAGES - 2;

    if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("pipelined_dadda_multiplier: WIDTH must be in 4..64");
    end
    if (STAGES < 2 || STAGES > 6) begin : g_bad_stages
        $error("pipelined_dadda_multiplier: STAGES must be in 2..6");
    end

    logic                advance_s;
    logic                accept_s;
    logic [STAGES:1]     vld_q;
    logic [TAG_W-1:0]    tag_q [1:STAGES];
    logic [WIDTH-1:0]    x_q;
    logic [WIDTH-1:0]    y_q;
    logic                sgn_q;
    logic [PW-1:0]       ans_q;
    logic [PW-1:0]       ans_d;
    rows_t               stg_in  [2:STAGES];
    rows_t               stg_out [2:STAGES];

    assign advance_s = out_ready | ~vld_q[STAGES];
    assign in_ready  = advance_s & ~rst;
    assign accept_s  = in_valid & in_ready;

    assign stg_in[2] = gen_pp(x_q, y_q, sgn_q);

    for (genvar k = 2; k <= STAGES; k++) begin : g_stage
        localparam int LO = stage_lo(k, NRED, NLEV);
        localparam int HI = stage_hi(k, NRED, NLEV);
        rows_t lv [0:NLEV];

        assign lv[0] = stg_in[k];
        for (genvar l = 0; l < NLEV; l++) begin : g_lvl
            if (l >= LO && l < HI) begin : g_csa
                assign lv[l+1] = csa_level(lv[l], height_after(WIDTH, l),
                                           height_after(WIDTH, l + 1));
            end else begin : g_pass
                assign lv[l+1] = lv[l];
            end
        end
        assign stg_out[k] = lv[NLEV];

        if (k < STAGES) begin : g_reg
            rows_t rows_q;

            // Carry-save rows between reduction stages; hold while stalled.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rows_q <= '0;
                end else if (advance_s) begin
                    rows_q <= stg_out[k];
                end
            end

            assign stg_in[k+1] = rows_q;
        end
    end

    assign ans_d = final_add(stg_out[STAGES]);

    // Valid/tag shift, operand capture and result register; ans/out_tag only change on delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            sgn_q <= 1'b0;
            ans_q <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                tag_q[k] <= '0;
            end
        end else if (advance_s) begin
            vld_q    <= {vld_q[STAGES-1:1], accept_s};
            x_q      <= x;
            y_q      <= y;
            sgn_q    <= is_signed;
            tag_q[1] <= in_tag;
            for (int k = 2; k < STAGES; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            if (vld_q[STAGES-1]) begin
                ans_q         <= ans_d;
                tag_q[STAGES] <= tag_q[STAGES-1];
            end
        end
    end

    assign out_valid = vld_q[STAGES];
    assign ans       = ans_q;
    assign out_tag   = tag_q[STAGES];
    assign busy      = |vld_q;

endmodule

// File: tb/tb_pipelined_dadda_multiplier.sv
// Directed bench for the 32-bit, 3-stage configuration: vector table plus
// back-to-back mode mixing, backpressure streaming and reset-in-flight sequences.
module tb_pipelined_dadda_multiplier;
    localparam int W   = 32;
    localparam int ST  = 3;
    localparam int TW  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    x;
    logic [W-1:0]    y;
    logic            is_signed;
    logic [TW-1:0]   in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  ans;
    logic [TW-1:0]   out_tag;
    logic            busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pipelined_dadda_multiplier #(.WIDTH(W), .STAGES(ST), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .is_signed(is_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .ans(ans),
        .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (s) begin
            return sa * sb;
        end else begin
            return ua * ub;
        end
    endfunction

    task automatic run_one(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        x         = v.a;
        y         = v.b;
        is_signed = v.s;
        in_tag    = 4'(idx);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) break;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check($sformatf("vec%0d_valid", idx), 64'(out_valid), 64'd1);
        check($sformatf("vec%0d_ans", idx), ans, v.exp);
        check($sformatf("vec%0d_tag", idx), 64'(out_tag), 64'(idx[3:0]));
        check($sformatf("vec%0d_latency", idx), 64'(lat), 64'(ST));
    endtask

    logic [31:0]   sx  [10];
    logic [31:0]   sy  [10];
    logic          ss  [10];
    logic [63:0]   sexp[10];
    logic [63:0]   got_ans [2];
    logic [3:0]    got_tag [2];
    int            sent;
    int            recv;
    int            seen;
    logic          held_v;
    logic [63:0]   held_ans;
    logic [3:0]    held_tag;

    initial begin
        vecs[0]  = '{32'd0,          32'd12345,      1'b1, 64'd0};
        vecs[1]  = '{32'd12345,      32'd0,          1'b0, 64'd0};
        vecs[2]  = '{32'd3,          32'd5,          1'b0, 64'd15};
        vecs[3]  = '{32'd123123123,  32'd121212121,  1'b0, 64'd14924014882973883};
        vecs[4]  = '{32'hFFFFFFFF,   32'd2,          1'b1, 64'hFFFFFFFF_FFFFFFFE};
        vecs[5]  = '{32'hFFFFFFFF,   32'd2,          1'b0, 64'h00000001_FFFFFFFE};
        vecs[6]  = '{32'h80000000,   32'h80000000,   1'b1, 64'h40000000_00000000};
        vecs[7]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 64'h00000000_80000000};
        vecs[8]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 64'hFFFFFFFE_00000001};
        vecs[9]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 64'h00000000_00000001};
        vecs[10] = '{32'h7FFFFFFF,   32'h7FFFFFFF,   1'b1, 64'h3FFFFFFF_00000001};
        vecs[11] = '{32'h80000000,   32'h7FFFFFFF,   1'b1, 64'hC0000000_80000000};
        vecs[12] = '{32'hFFFFFFFB,   32'd7,          1'b1, 64'hFFFFFFFF_FFFFFFDD};
        vecs[13] = '{32'd12345678,   32'd100,        1'b0, 64'd1234567800};
        vecs[14] = '{32'h80000000,   32'h80000000,   1'b0, 64'h40000000_00000000};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; is_signed = 1'b0; in_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("in_ready_during_rst", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ans", ans, 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 15; i++) begin
            run_one(vecs[i], i);
        end

        // Two modes back-to-back on consecutive edges.
        @(negedge clk);
        x = 32'hFFFFFFFF; y = 32'd2; is_signed = 1'b1; in_tag = 4'd5;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        is_signed = 1'b0; in_tag = 4'd6;
        @(negedge clk);
        in_valid = 1'b0;
        recv = 0;
        got_ans[0] = '0; got_ans[1] = '0; got_tag[0] = '0; got_tag[1] = '0;
        for (int c = 0; c < 20 && recv < 2; c++) begin
            if (out_valid) begin
                got_ans[recv] = ans;
                got_tag[recv] = out_tag;
                recv++;
            end
            @(negedge clk);
        end
        check("mix_count", 64'(recv), 64'd2);
        check("mix_ans0", got_ans[0], 64'hFFFFFFFF_FFFFFFFE);
        check("mix_tag0", 64'(got_tag[0]), 64'd5);
        check("mix_ans1", got_ans[1], 64'h00000001_FFFFFFFE);
        check("mix_tag1", 64'(got_tag[1]), 64'd6);

        // Full-rate stream of 10 with a 5-cycle output stall in the middle.
        for (int i = 0; i < 10; i++) begin
            sx[i]   = (i % 2 == 0) ? 32'hFFFF0000 + 32'(i * 977) : 32'(i * 100003 + 11);
            sy[i]   = 32'(i * 31 + 3) ^ ((i % 3 == 0) ? 32'h80000000 : 32'd0);
            ss[i]   = (i % 2 == 0);
            sexp[i] = model(sx[i], sy[i], ss[i]);
        end
        sent = 0; recv = 0; held_v = 1'b0; held_ans = '0; held_tag = '0;
        for (int cyc = 0; cyc < 60 && recv < 10; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc < 9);
            in_valid  = (sent < 10);
            if (sent < 10) begin
                x = sx[sent]; y = sy[sent]; is_signed = ss[sent]; in_tag = 4'(sent);
            end
            #1;
            if (held_v) begin
                check("stall_hold_ans", ans, held_ans);
                check("stall_hold_tag", 64'(out_tag), 64'(held_tag));
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", 64'(in_ready), 64'd0);
            end
            if (out_valid && out_ready) begin
                check($sformatf("stream%0d_ans", recv), ans, sexp[recv]);
                check($sformatf("stream%0d_tag", recv), 64'(out_tag), 64'(recv[3:0]));
                recv++;
            end
            held_v   = out_valid && !out_ready;
            held_ans = ans;
            held_tag = out_tag;
            if (in_valid && in_ready) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_count", 64'(recv), 64'd10);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("stream_no_dup", 64'(seen), 64'd0);
        check("stream_idle", 64'(busy), 64'd0);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            x = 32'(1000 + i); y = 32'd3; is_signed = 1'b0; in_tag = 4'(9 + i);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ans", ans, 64'd0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_never_delivered", 64'(seen), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
